regfile_wr_arbiter: RTL and testbench
=====================================

// Module: regfile_wr_arbiter
// PURPOSE
//  Shares the register file's single write port among NUM_REQ writeback sources (pipeline WB,
//  multi-cycle mul/div, CP0/load return) using valid/ready handshakes. Registers the winning write
//  onto rf_we/rf_waddr/rf_wdata, one stage ahead of the register file.
//  Keeps a per-register reservation scoreboard so decode can stall on registers owed by a multi-cycle unit.
// PARAMETERS
//  NUM_REQ   3   number of write requesters (index 0 = pipeline WB)
//  ADDR_W    5   register address width
//  DATA_W    32  register data width
//  NUM_REGS  32  registers tracked by the scoreboard (2**ADDR_W)
// PORTS
//  clk        in   1               clock; all state updates on posedge
//  rst_n      in   1               reset, asynchronous, active-low
//  req_valid  in   NUM_REQ         requester i has a write pending
//  req_ready  out  NUM_REQ         one-hot grant; write i accepted this cycle
//  req_addr   in   NUM_REQ*ADDR_W  packed destination addresses, slice i = requester i
//  req_data   in   NUM_REQ*DATA_W  packed write data, slice i = requester i
//  rf_we      out  1               register-file write enable (registered)
//  rf_waddr   out  ADDR_W          register-file write address (registered)
//  rf_wdata   out  DATA_W          register-file write data (registered)
//  rsv_valid  in   1               reserve rsv_addr for a future write (multi-cycle op issued)
//  rsv_addr   in   ADDR_W          register to reserve
//  qaddr1     in   ADDR_W          decode source-1 address to check
//  qaddr2     in   ADDR_W          decode source-2 address to check
//  busy1      out  1               qaddr1 reserved, result not yet granted (combinational)
//  busy2      out  1               qaddr2 reserved, result not yet granted (combinational)
// BEHAVIOUR
//  - Reset (async assert, sync-safe release): rf_we=0, rf_waddr=0, rf_wdata=0, scoreboard all 0, RR pointer=NUM_REQ-1.
//  - Grant is combinational from req_valid: at most one req_ready bit set, and only on a valid requester.
//  - The port always accepts, so a lone valid requester is granted the same cycle.
//  - Handshake: a requester holds valid/addr/data stable until it sees ready; once accepted, it may drop valid or present the next write.
//  - Latency: an accepted write appears on rf_we/rf_waddr/rf_wdata on the next posedge, exactly 1 cycle.
//  - With no grant, rf_we=0 next cycle; rf_waddr and rf_wdata hold their previous values.
//  - Address 0: accepted (ready=1) but dropped; rf_we stays 0 and the scoreboard is unaffected.
//  - Scoreboard set: rsv_valid and rsv_addr!=0 set sb[rsv_addr] at the posedge.
//  - Scoreboard clear: a grant to address a clears sb[a] at the posedge.
//  - Clearing on grant is safe because the register file bypasses wdata while we is high.
//  - Simultaneous set and clear of the same register: set wins, since the reservation is the newer op.
//  - busy1 = (qaddr1!=0) & sb[qaddr1]; busy2 is the same for qaddr2. Both reflect the registered scoreboard only.
//  - Two requesters writing the same register in consecutive grants: both writes issue in grant order; the last one wins in the register file.
//  - Reset mid-operation drops any pending output write; requesters must re-present after reset.
// CONFIGURATION
//  REGWR_ARB_RR_EN defined: round-robin. Search starts at (ptr+1) mod NUM_REQ; ptr updates to the granted index on each grant and holds otherwise.
//  REGWR_ARB_RR_EN undefined: fixed priority, lowest index wins. No pointer register is built.
// STRUCTURE
//  - Widths come from the shared header: REG_ADDR_WIDTH, REG_DATA_WIDTH and REG_NUM. Add NUM_WB_REQ there.
//  - Sub-module rr_arbiter(NUM_REQ): req vector in, one-hot grant out, holds the pointer and honours REGWR_ARB_RR_EN.
//  - The scoreboard and output register stay in this module.
// TESTING
//  1. Reset with all valid high -> ready=0 and rf_we=0 during reset; first cycle after release grants req0.
//  2. Only req1 valid, addr=5, data=0xDEADBEEF -> ready=3'b010 same cycle; next cycle rf_we=1, waddr=5, wdata=0xDEADBEEF.
//  3. All three valid held 6 cycles (RR) -> grant order 0,1,2,0,1,2. Without the macro -> 0,0,0,0,0,0.
//  4. rsv addr 8; next cycle qaddr1=8 -> busy1=1. req2 writes addr 8 -> busy1=0 the cycle after grant; rf_we=1 for addr 8 the same cycle.
//  5. rsv addr 9 while req0 writes addr 9 in the same cycle -> sb[9]=1 afterward, busy stays 1.
//  6. req0 addr=0, data=0x1234 -> ready=1, rf_we stays 0. rsv addr 0 -> busy always 0. Async reset mid-stream -> rf_we=0 immediately.

Source files
------------

// File: rtl/regfile_wr_arbiter_pkg.sv
// Shared register-file widths and the write payload type.
//   REG_ADDR_WIDTH / REG_DATA_WIDTH / REG_NUM : register file geometry
//   NUM_WB_REQ                                : writeback sources sharing the write port
package regfile_wr_arbiter_pkg;

   localparam int unsigned REG_ADDR_WIDTH = 5;
   localparam int unsigned REG_DATA_WIDTH = 32;
   localparam int unsigned REG_NUM        = 32;
   localparam int unsigned NUM_WB_REQ     = 3;

   // One register-file write: destination and value.
   typedef struct packed {
      logic [REG_ADDR_WIDTH-1:0] addr;
      logic [REG_DATA_WIDTH-1:0] data;
   } rf_wr_t;

endpackage

// File: rtl/regfile_wr_arbiter_if.sv
// Writeback request bus: NUM_REQ valid/ready channels with packed address/data slices.
//   req_valid : requester i has a write pending
//   req_ready : one-hot grant back to the requesters
//   req_addr  : slice i = destination of requester i
//   req_data  : slice i = write data of requester i
// master = requesters, slave = arbiter.
interface regfile_wr_arbiter_if
   import regfile_wr_arbiter_pkg::*;
#(
   parameter int unsigned NUM_REQ = NUM_WB_REQ,
   parameter int unsigned ADDR_W  = REG_ADDR_WIDTH,
   parameter int unsigned DATA_W  = REG_DATA_WIDTH
);
   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ-1:0]        req_ready;
   logic [NUM_REQ*ADDR_W-1:0] req_addr;
   logic [NUM_REQ*DATA_W-1:0] req_data;

   modport master (output req_valid, output req_addr, output req_data, input req_ready);
   modport slave  (input req_valid, input req_addr, input req_data, output req_ready);
endinterface

// File: rtl/regfile_wr_arbiter_rr_arbiter.sv
// Request arbiter for the register-file write port.
//   req_i    : request vector
//   gnt_c_o  : one-hot grant, combinational from req_i
//   clk/rst_n: only present with REGWR_ARB_RR_EN (round-robin pointer)
// REGWR_ARB_RR_EN defined  : round-robin, search starts after the last granted index.
// REGWR_ARB_RR_EN undefined: fixed priority, lowest index wins, no state.
module regfile_wr_arbiter_rr_arbiter #(
   parameter int unsigned NUM_REQ = 3
) (
`ifdef REGWR_ARB_RR_EN
   input  logic               clk,
   input  logic               rst_n,
`endif
   input  logic [NUM_REQ-1:0] req_i,
   output logic [NUM_REQ-1:0] gnt_c_o
);

`ifdef REGWR_ARB_RR_EN
   localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [IDX_W-1:0] ptr_q, ptr_d;
   logic [IDX_W-1:0] idx;

   // Scan from ptr+1 around the ring; first live request wins and becomes the new pointer.
   always_comb begin
      gnt_c_o = '0;
      ptr_d   = ptr_q;
      idx     = '0;
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
         idx = IDX_W'((32'(ptr_q) + k) % NUM_REQ);
         if ((gnt_c_o == '0) && req_i[idx]) begin
            gnt_c_o[idx] = 1'b1;
            ptr_d        = idx;
         end
      end
   end

   // Reset pointer to the last index so requester 0 is searched first.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ptr_q <= IDX_W'(NUM_REQ - 1);
      else        ptr_q <= ptr_d;
   end
`else
   // Lowest set request wins.
   always_comb begin
      gnt_c_o = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if ((gnt_c_o == '0) && req_i[i]) gnt_c_o[i] = 1'b1;
      end
   end
`endif

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Shares the single register-file write port among NUM_REQ writeback sources and keeps a
// reservation scoreboard for registers owed by multi-cycle units.
//   clk, rst_n          : clock, async active-low reset
//   bus (slave)         : valid/ready write requests, grant is same-cycle
//   rf_we/waddr/wdata_o : registered winning write, one cycle after grant
//   rsv_valid_i/addr_i  : reserve a register for a future write
//   qaddr1_i/qaddr2_i   : decode source addresses to check
//   busy1_c_o/busy2_c_o : source is reserved and not yet written (combinational)
// Arbitration policy selected by REGWR_ARB_RR_EN (round-robin when defined, else fixed priority).
module regfile_wr_arbiter
   import regfile_wr_arbiter_pkg::*;
#(
   parameter int unsigned NUM_REQ  = NUM_WB_REQ,
   parameter int unsigned ADDR_W   = REG_ADDR_WIDTH,
   parameter int unsigned DATA_W   = REG_DATA_WIDTH,
   parameter int unsigned NUM_REGS = REG_NUM
) (
   input  logic                 clk,
   input  logic                 rst_n,
   regfile_wr_arbiter_if.slave  bus,
   output logic                 rf_we_o,
   output logic [ADDR_W-1:0]    rf_waddr_o,
   output logic [DATA_W-1:0]    rf_wdata_o,
   input  logic                 rsv_valid_i,
   input  logic [ADDR_W-1:0]    rsv_addr_i,
   input  logic [ADDR_W-1:0]    qaddr1_i,
   input  logic [ADDR_W-1:0]    qaddr2_i,
   output logic                 busy1_c_o,
   output logic                 busy2_c_o
);

   logic [NUM_REQ-1:0]  req_live, gnt;
   logic [ADDR_W-1:0]   gnt_addr;
   logic [DATA_W-1:0]   gnt_data;
   logic                wr_en;

   logic                rf_we_q, rf_we_d;
   logic [ADDR_W-1:0]   rf_waddr_q, rf_waddr_d;
   logic [DATA_W-1:0]   rf_wdata_q, rf_wdata_d;
   logic [NUM_REGS-1:0] sb_q, sb_d;

   // No grants while reset is asserted.
   assign req_live = bus.req_valid & {NUM_REQ{rst_n}};

   regfile_wr_arbiter_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
`ifdef REGWR_ARB_RR_EN
      .clk     (clk),
      .rst_n   (rst_n),
`endif
      .req_i   (req_live),
      .gnt_c_o (gnt)
   );

   assign bus.req_ready = gnt;

   // One-hot AND-OR select of the granted requester's write.
   always_comb begin
      gnt_addr = '0;
      gnt_data = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         gnt_addr |= bus.req_addr[i*ADDR_W +: ADDR_W] & {ADDR_W{gnt[i]}};
         gnt_data |= bus.req_data[i*DATA_W +: DATA_W] & {DATA_W{gnt[i]}};
      end
   end

   // Writes to register 0 are accepted but discarded.
   assign wr_en = (|gnt) && (gnt_addr != '0);

   // Next state: output write register and scoreboard; a same-cycle reservation beats the clear.
   always_comb begin
      rf_we_d    = wr_en;
      rf_waddr_d = rf_waddr_q;
      rf_wdata_d = rf_wdata_q;
      sb_d       = sb_q;
      if (wr_en) begin
         rf_waddr_d       = gnt_addr;
         rf_wdata_d       = gnt_data;
         sb_d[gnt_addr]   = 1'b0;
      end
      if (rsv_valid_i && (rsv_addr_i != '0)) sb_d[rsv_addr_i] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rf_we_q    <= 1'b0;
         rf_waddr_q <= '0;
         rf_wdata_q <= '0;
         sb_q       <= '0;
      end else begin
         rf_we_q    <= rf_we_d;
         rf_waddr_q <= rf_waddr_d;
         rf_wdata_q <= rf_wdata_d;
         sb_q       <= sb_d;
      end
   end

   assign rf_we_o    = rf_we_q;
   assign rf_waddr_o = rf_waddr_q;
   assign rf_wdata_o = rf_wdata_q;

   assign busy1_c_o = (qaddr1_i != '0) && sb_q[qaddr1_i];
   assign busy2_c_o = (qaddr2_i != '0) && sb_q[qaddr2_i];

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Randomized self-checking bench for regfile_wr_arbiter with a behavioural reference model.
module tb_regfile_wr_arbiter;
   import regfile_wr_arbiter_pkg::*;

   localparam int unsigned N  = NUM_WB_REQ;
   localparam int unsigned AW = REG_ADDR_WIDTH;
   localparam int unsigned DW = REG_DATA_WIDTH;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          rf_we;
   logic [AW-1:0] rf_waddr;
   logic [DW-1:0] rf_wdata;
   logic          rsv_valid = 1'b0;
   logic [AW-1:0] rsv_addr = '0;
   logic [AW-1:0] qaddr1 = '0;
   logic [AW-1:0] qaddr2 = '0;
   logic          busy1, busy2;

   always #5 clk = ~clk;

   regfile_wr_arbiter_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

   regfile_wr_arbiter dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (bus),
      .rf_we_o     (rf_we),
      .rf_waddr_o  (rf_waddr),
      .rf_wdata_o  (rf_wdata),
      .rsv_valid_i (rsv_valid),
      .rsv_addr_i  (rsv_addr),
      .qaddr1_i    (qaddr1),
      .qaddr2_i    (qaddr2),
      .busy1_c_o   (busy1),
      .busy2_c_o   (busy2)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: pending-write register, reserved-register set, last winner.
   bit     m_we;
   rf_wr_t m_wr;
   bit     m_sb [REG_NUM];
   int     m_ptr;
   int     last_gi;
   logic [N-1:0] last_g;

   function automatic void model_reset();
      m_we  = 1'b0;
      m_wr  = '0;
      foreach (m_sb[r]) m_sb[r] = 1'b0;
      m_ptr = N - 1;
   endfunction

   function automatic int model_pick();
      if (!rst_n) return -1;
`ifdef REGWR_ARB_RR_EN
      for (int k = 1; k <= N; k++) begin
         int c;
         c = (m_ptr + k) % N;
         if (bus.req_valid[c]) return c;
      end
`else
      for (int c = 0; c < N; c++) if (bus.req_valid[c]) return c;
`endif
      return -1;
   endfunction

   function automatic bit model_busy(input logic [AW-1:0] a);
      return (a != 0) && m_sb[a];
   endfunction

   // One cycle: check grant/busy, clock, update model, check registered write.
   task automatic step();
      int gi;
      logic [N-1:0] g;
      logic [AW-1:0] a;
      #1;
      gi = model_pick();
      g  = '0;
      if (gi >= 0) g[gi] = 1'b1;
      check_val("req_ready", 64'(bus.req_ready), 64'(g));
      check_val("busy1", 64'(busy1), 64'(model_busy(qaddr1)));
      check_val("busy2", 64'(busy2), 64'(model_busy(qaddr2)));
      @(posedge clk);
      m_we = 1'b0;
      if (gi >= 0) begin
         a = bus.req_addr[gi*AW +: AW];
         if (a != 0) begin
            m_we      = 1'b1;
            m_wr.addr = a;
            m_wr.data = bus.req_data[gi*DW +: DW];
            m_sb[a]   = 1'b0;
         end
         m_ptr = gi;
      end
      if (rsv_valid && rsv_addr != 0) m_sb[rsv_addr] = 1'b1;
      last_gi = gi;
      last_g  = g;
      #1;
      check_val("rf_we", 64'(rf_we), 64'(m_we));
      check_val("rf_waddr", 64'(rf_waddr), 64'(m_wr.addr));
      check_val("rf_wdata", 64'(rf_wdata), 64'(m_wr.data));
      @(negedge clk);
   endtask

   task automatic set_req(input int i, input bit v, input logic [AW-1:0] a, input logic [DW-1:0] d);
      bus.req_valid[i]          = v;
      bus.req_addr[i*AW +: AW]  = a;
      bus.req_data[i*DW +: DW]  = d;
   endtask

   task automatic clear_all();
      for (int i = 0; i < N; i++) set_req(i, 1'b0, '0, '0);
      rsv_valid = 1'b0;
      rsv_addr  = '0;
      qaddr1    = '0;
      qaddr2    = '0;
   endtask

   int exp_ord [6];

   initial begin
`ifdef REGWR_ARB_RR_EN
      exp_ord = '{0, 1, 2, 0, 1, 2};
`else
      exp_ord = '{0, 0, 0, 0, 0, 0};
`endif
      model_reset();
      clear_all();
      // Reset with every requester valid: no grant, no write.
      set_req(0, 1'b1, AW'(1), 32'h1111_0000);
      set_req(1, 1'b1, AW'(2), 32'h2222_0000);
      set_req(2, 1'b1, AW'(3), 32'h3333_0000);
      repeat (3) @(negedge clk);
      #1;
      check_val("rst_ready", 64'(bus.req_ready), 64'(0));
      check_val("rst_we", 64'(rf_we), 64'(0));
      check_val("rst_waddr", 64'(rf_waddr), 64'(0));
      rst_n = 1'b1;

      // All three held valid: grant order depends on policy.
      for (int k = 0; k < 6; k++) begin
         step();
         check_val("grant_order", 64'(last_gi), 64'(exp_ord[k]));
      end

      // Lone requester 1 granted same cycle, write one cycle later.
      clear_all();
      set_req(1, 1'b1, AW'(5), 32'hDEAD_BEEF);
      #1;
      check_val("lone_ready", 64'(bus.req_ready), 64'(3'b010));
      step();
      check_val("lone_we", 64'(rf_we), 64'(1));
      check_val("lone_waddr", 64'(rf_waddr), 64'(5));
      check_val("lone_wdata", 64'(rf_wdata), 64'(32'hDEAD_BEEF));

      // Reserve 8, then requester 2 writes it back.
      clear_all();
      rsv_valid = 1'b1;
      rsv_addr  = AW'(8);
      step();
      rsv_valid = 1'b0;
      qaddr1    = AW'(8);
      #1;
      check_val("rsv_busy1", 64'(busy1), 64'(1));
      set_req(2, 1'b1, AW'(8), 32'h0000_0808);
      step();
      set_req(2, 1'b0, '0, '0);
      #1;
      check_val("clr_busy1", 64'(busy1), 64'(0));
      check_val("clr_we", 64'(rf_we), 64'(1));
      check_val("clr_waddr", 64'(rf_waddr), 64'(8));

      // Same-cycle reserve and write of 9: reservation survives.
      qaddr1    = AW'(9);
      rsv_valid = 1'b1;
      rsv_addr  = AW'(9);
      set_req(0, 1'b1, AW'(9), 32'h0000_0909);
      step();
      clear_all();
      qaddr1 = AW'(9);
      #1;
      check_val("setwins_busy", 64'(busy1), 64'(1));
      check_val("setwins_waddr", 64'(rf_waddr), 64'(9));

      // Write to register 0 is accepted and dropped; reserving 0 never sets busy.
      clear_all();
      set_req(0, 1'b1, AW'(0), 32'h0000_1234);
      rsv_valid = 1'b1;
      rsv_addr  = AW'(0);
      #1;
      check_val("r0_ready", 64'(bus.req_ready), 64'(3'b001));
      step();
      check_val("r0_we", 64'(rf_we), 64'(0));
      rsv_valid = 1'b0;
      #1;
      check_val("r0_busy", 64'(busy1), 64'(0));

      // Async reset in the middle of a write.
      clear_all();
      set_req(0, 1'b1, AW'(3), 32'hCAFE_F00D);
      step();
      #2;
      rst_n = 1'b0;
      #1;
      check_val("async_we", 64'(rf_we), 64'(0));
      check_val("async_ready", 64'(bus.req_ready), 64'(0));
      model_reset();
      @(negedge clk);
      clear_all();
      rst_n = 1'b1;

      // Randomized traffic with valid/ready handshake and reservations.
      last_g = '0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         for (int i = 0; i < N; i++) begin
            if (!bus.req_valid[i] || last_g[i]) begin
               set_req(i, ($urandom_range(0, 9) < 6), AW'($urandom_range(0, 31)), $urandom);
            end
         end
         rsv_valid = ($urandom_range(0, 9) < 3);
         rsv_addr  = AW'($urandom_range(0, 31));
         qaddr1    = AW'($urandom_range(0, 31));
         qaddr2    = AW'($urandom_range(0, 31));
         step();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
